// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode seven-segment scanner with double-buffered digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits,
    output logic [6:0]  segments,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int unsigned   CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [1:0]    IDX_LAST = 2'd3;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   shd, shd_nxt;
    logic [15:0]   dsp, dsp_nxt;
    logic [3:0]    cur;
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;
    logic          tc;
    logic          wrap;
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0]    lead_zero;
`endif

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b000_0001;
            4'd1:    s = 7'b100_1111;
            4'd2:    s = 7'b001_0010;
            4'd3:    s = 7'b000_0110;
            4'd4:    s = 7'b100_1100;
            4'd5:    s = 7'b010_0100;
            4'd6:    s = 7'b010_0000;
            4'd7:    s = 7'b000_1111;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b000_0100;
            default: s = 7'b111_1110;
        endcase
        return s;
    endfunction

    always_comb begin
        tc      = (cnt == CNT_LAST);
        wrap    = tc && (idx == IDX_LAST);
        cnt_nxt = tc ? '0 : cnt + 1'b1;
        idx_nxt = tc ? idx + 2'd1 : idx;
        shd_nxt = load ? digits : shd;
        // shd_nxt already carries a same-edge load, giving the wrap-edge bypass
        dsp_nxt = wrap ? shd_nxt : dsp;
        cur     = dsp_nxt[{idx_nxt, 2'b00} +: 4];
        seg_nxt = decode(cur);
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero[3] = (dsp_nxt[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (dsp_nxt[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (dsp_nxt[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
        if (lead_zero[idx_nxt]) begin
            seg_nxt = '1;
        end
`endif
        an_nxt  = ~(4'b0001 << idx_nxt);
    end

    // Outputs are computed from the next-state scan position so an and segments move together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            shd        <= '0;
            dsp        <= '0;
            an         <= '1;
            segments   <= '1;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shd        <= shd_nxt;
            dsp        <= dsp_nxt;
            an         <= an_nxt;
            segments   <= seg_nxt;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: two instances (REFRESH_DIV 4 and 2) share stimulus,
// a frame-level reference model predicts every output cycle.
module tb_seven_seg_scanner;

    localparam int unsigned DIVS[2] = '{4, 2};
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        tick;
        int unsigned n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [6:0]  seg [2];
    logic [3:0]  an [2];
    logic        tick [2];

    logic [6:0]  dec [16] = '{7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
                              7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
                              7'b000_0000, 7'b000_0100, 7'b111_1110, 7'b111_1110,
                              7'b111_1110, 7'b111_1110, 7'b111_1110, 7'b111_1110};

    int unsigned n [2];
    logic [15:0] pend [2];
    logic [15:0] shown [2];
    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned compared = 0;
    int unsigned mismatched = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(.REFRESH_DIV(4)) dut0 (
        .clk(clk), .reset(reset), .load(load), .digits(digits),
        .segments(seg[0]), .an(an[0]), .frame_tick(tick[0])
    );

    seven_seg_scanner #(.REFRESH_DIV(2)) dut1 (
        .clk(clk), .reset(reset), .load(load), .digits(digits),
        .segments(seg[1]), .an(an[1]), .frame_tick(tick[1])
    );

    function automatic void check(string nm, int inst, int unsigned cyc,
                                  logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, inst, cyc, act, exp);
        end
    endfunction

    // Frame-level model: edge count since reset gives scan position; frames latch the last load.
    function automatic exp_t model_edge(int i, logic rst, logic ld, logic [15:0] dg);
        exp_t        e;
        int unsigned d;
        int unsigned fr;
        logic [15:0] upper;
        fr = 4 * DIVS[i];
        if (rst) begin
            n[i] = 0; pend[i] = '0; shown[i] = '0;
            e.an = 4'hF; e.seg = 7'h7F; e.tick = 1'b0;
        end else begin
            n[i]++;
            if (ld) pend[i] = dg;
            e.tick = ((n[i] % fr) == 0);
            if (e.tick) shown[i] = pend[i];
            d = (n[i] / DIVS[i]) % 4;
            e.an = 4'hF ^ (4'b0001 << d);
            upper = shown[i] >> (4 * d);
            e.seg = dec[upper[3:0]];
            if (BLANK && d > 0 && upper == 16'd0) e.seg = 7'h7F;
        end
        e.n = n[i];
        return e;
    endfunction

    task automatic step(input logic rst, input logic ld, input logic [15:0] dg);
        @(negedge clk);
        reset = rst; load = ld; digits = dg;
        @(posedge clk);
        q0.push_back(model_edge(0, reset, load, digits));
        q1.push_back(model_edge(1, reset, load, digits));
    endtask

    task automatic idle(input int unsigned k);
        for (int unsigned j = 0; j < k; j++) step(1'b0, 1'b0, 16'($urandom));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q0.size() > 0) begin
                e = q0.pop_front();
                check("an", 0, e.n, 32'(an[0]), 32'(e.an));
                check("segments", 0, e.n, 32'(seg[0]), 32'(e.seg));
                check("frame_tick", 0, e.n, 32'(tick[0]), 32'(e.tick));
            end
            while (q1.size() > 0) begin
                e = q1.pop_front();
                check("an", 1, e.n, 32'(an[1]), 32'(e.an));
                check("segments", 1, e.n, 32'(seg[1]), 32'(e.seg));
                check("frame_tick", 1, e.n, 32'(tick[1]), 32'(e.tick));
            end
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0, 16'h0);
        idle(40);
        // single load mid-frame
        while ((n[0] % 16) != 1) idle(1);
        step(1'b0, 1'b1, 16'h1234);
        idle(36);
        // two loads in one frame: last wins
        while ((n[0] % 16) != 2) idle(1);
        step(1'b0, 1'b1, 16'h5678);
        idle(3);
        step(1'b0, 1'b1, 16'h9ABC);
        idle(36);
        // load exactly on the wrap edge
        while (((n[0] + 1) % 16) != 0) idle(1);
        step(1'b0, 1'b1, 16'h0007);
        idle(20);
        // reload then async reset while digit 2 is active on instance 0
        step(1'b0, 1'b1, 16'h4321);
        while (((n[0] / 4) % 4) != 2) idle(1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async_an", i, n[i], 32'(an[i]), 32'hF);
            check("async_seg", i, n[i], 32'(seg[i]), 32'h7F);
            check("async_tick", i, n[i], 32'(tick[i]), 32'h0);
        end
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        idle(36);
        step(1'b0, 1'b1, 16'h0900);
        idle(36);
        for (int unsigned j = 0; j < 300; j++)
            step(1'b0, ($urandom_range(0, 5) == 0), 16'($urandom));
        idle(36);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
